serial_fa_sequencer: RTL and testbench



---
 rtl/serial_fa_sequencer_if.sv | 36 +++
 rtl/serial_fa_sequencer.sv | 114 +++++++++++
 tb/tb_serial_fa_sequencer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/serial_fa_sequencer_if.sv
// Bundles the request/result handshake and the full-adder drive/sense wires
// of serial_fa_sequencer. "slave" is the sequencer side; "master" is the
// environment (requester plus the external full adder).
//   start/sub/a/b      : request, sampled by the sequencer only in IDLE
//   busy/done          : busy while serialising, done pulses one cycle
//   sum/cout/ovf       : result, held until the next accepted start
//   fa_in1/2/3         : drive to the external full adder
//   fa_sum/fa_cout     : sense from the external full adder
interface serial_fa_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             fa_in1;
  logic             fa_in2;
  logic             fa_in3;
  logic             fa_sum;
  logic             fa_cout;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport slave (
    input  start, sub, a, b, fa_sum, fa_cout,
    output fa_in1, fa_in2, fa_in3, busy, done, sum, cout, ovf
  );

  modport master (
    output start, sub, a, b, fa_sum, fa_cout,
    input  fa_in1, fa_in2, fa_in3, busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_fa_sequencer.sv
// Purpose: bit-serial WIDTH-bit add/sub around one external 1-bit full adder.
// Latency: start edge + WIDTH RUN edges; done high the cycle after; WIDTH+2 per op.
// Backpressure: none; start is accepted only in IDLE and ignored in RUN/DONE.
// Ports: clk, rst_n (async, active-low) plain; everything else through
// bus (serial_fa_sequencer_if.slave): request start/sub/a/b, status busy/done,
// result sum/cout/ovf, full-adder drive fa_in1..3 and sense fa_sum/fa_cout.
module serial_fa_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  serial_fa_sequencer_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             busy_q;
  logic             done_q;
  logic             last;

  assign last = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last)      state_d = DONE;
      DONE:                   state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_q     <= bus.a;
            // Subtraction is a + ~b + 1: invert B and seed the carry with 1.
            b_q     <= bus.sub ? ~bus.b : bus.b;
            carry_q <= bus.sub;
            cnt_q   <= '0;
            sum_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          sum_q <= {bus.fa_sum, sum_q[WIDTH-1:1]};
          // Zero-fill shifts leave A/B empty once all bits are consumed, so
          // the adder drive is naturally 0 in DONE/IDLE without gating logic.
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          if (last) begin
            cout_q  <= bus.fa_cout;
            ovf_q   <= carry_q ^ bus.fa_cout;
            // Final carry lives in cout; clearing the flop keeps fa_in3 low
            // outside RUN straight from a register.
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            carry_q <= bus.fa_cout;
            cnt_q   <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          done_q <= 1'b0;
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.fa_in1 = a_q[0];
  assign bus.fa_in2 = b_q[0];
  assign bus.fa_in3 = carry_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.sum    = sum_q;
  assign bus.cout   = cout_q;
  assign bus.ovf    = ovf_q;
endmodule

// File: tb/tb_serial_fa_sequencer.sv
`timescale 1ns/100ps
module tb_serial_fa_sequencer;
  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  serial_fa_sequencer_if #(.WIDTH(W)) bus ();

  serial_fa_sequencer #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // External full adder model.
  assign bus.fa_sum  = bus.fa_in1 ^ bus.fa_in2 ^ bus.fa_in3;
  assign bus.fa_cout = (bus.fa_in1 & bus.fa_in2) | (bus.fa_in1 & bus.fa_in3) |
                       (bus.fa_in2 & bus.fa_in3);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_ovf;
    logic         hold;
  } vec_t;

  vec_t vecs [9];
  logic [2:0] fa_log [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one operation; optionally keeps a conflicting start asserted
  // through RUN and DONE. Returns with the bench in the DONE cycle.
  task automatic run_op(input logic s, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic hold);
    int n;
    check("idle_fa_drive", {29'd0, bus.fa_in1, bus.fa_in2, bus.fa_in3}, 32'd0);
    bus.start = 1'b1;
    bus.sub   = s;
    bus.a     = av;
    bus.b     = bv;
    step();
    if (hold) begin
      bus.a = 8'hAA;
      bus.b = 8'h55;
      bus.sub = 1'b0;
    end else begin
      bus.start = 1'b0;
    end
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      if (n < 16) fa_log[n] = {bus.fa_in1, bus.fa_in2, bus.fa_in3};
      check("done_low_in_run", {31'd0, bus.done}, 32'd0);
      n++;
      step();
    end
    check("busy_cycles", n, W);
    check("done_pulse", {31'd0, bus.done}, 32'd1);
    check("done_fa_drive", {29'd0, bus.fa_in1, bus.fa_in2, bus.fa_in3}, 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.sub = 1'b0;
    bus.a = '0;
    bus.b = '0;

    //              sub   a      b      sum    cout  ovf   hold
    vecs[0] = '{1'b0, 8'h3C, 8'h5A, 8'h96, 1'b0, 1'b1, 1'b1};
    vecs[1] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b0};

    #12;
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_sum",  {24'd0, bus.sum},  32'd0);
    check("rst_cout_ovf", {30'd0, bus.cout, bus.ovf}, 32'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].hold);
      check($sformatf("v%0d_sum", i), {24'd0, bus.sum}, {24'd0, vecs[i].exp_sum});
      check($sformatf("v%0d_cout", i), {31'd0, bus.cout}, {31'd0, vecs[i].exp_cout});
      check($sformatf("v%0d_ovf", i), {31'd0, bus.ovf}, {31'd0, vecs[i].exp_ovf});
      step();
      check("done_clears", {31'd0, bus.done}, 32'd0);
      if (vecs[i].hold) begin
        // The DONE->IDLE edge saw start=1 and must not have accepted it.
        bus.start = 1'b0;
        check("held_start_busy", {31'd0, bus.busy}, 32'd0);
        step();
        check("held_start_busy2", {31'd0, bus.busy}, 32'd0);
        check("held_start_sum", {24'd0, bus.sum}, 32'h96);
      end
      check("result_held_idle", {24'd0, bus.sum}, {24'd0, vecs[i].exp_sum});
      if (i == 7) begin
        // 0x01 + 0x01: bit0 1+1+0, bit1 0+0+carry, then all zero.
        check("fa_c1", {29'd0, fa_log[0]}, 32'b110);
        check("fa_c2", {29'd0, fa_log[1]}, 32'b001);
        for (int k = 2; k < W; k++)
          check($sformatf("fa_c%0d", k + 1), {29'd0, fa_log[k]}, 32'd0);
      end
    end

    // Start a new op (clears sum), then abort with reset in RUN cycle 4.
    bus.start = 1'b1; bus.sub = 1'b0; bus.a = 8'hFF; bus.b = 8'hFF;
    step();
    bus.start = 1'b0;
    check("abort_start_clears_sum", {24'd0, bus.sum}, 32'd0);
    check("abort_cout_kept", {31'd0, bus.cout}, 32'd1);
    step(); step(); step();
    check("abort_busy_before", {31'd0, bus.busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #0.5;
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_done", {31'd0, bus.done}, 32'd0);
    check("abort_sum",  {24'd0, bus.sum},  32'd0);
    check("abort_cout_ovf", {30'd0, bus.cout, bus.ovf}, 32'd0);
    check("abort_fa", {29'd0, bus.fa_in1, bus.fa_in2, bus.fa_in3}, 32'd0);
    #0.5;
    rst_n = 1'b1;
    step();
    check("abort_idle", {31'd0, bus.busy}, 32'd0);
    run_op(1'b0, 8'h01, 8'h02, 1'b0);
    check("post_abort_sum", {24'd0, bus.sum}, 32'h03);
    check("post_abort_cout_ovf", {30'd0, bus.cout, bus.ovf}, 32'd0);
    step();
    check("post_abort_done_clears", {31'd0, bus.done}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end
endmodule
